// File: rtl/butterfly_radix4_pipe_pkg.sv
// rtl/butterfly_radix4_pipe_pkg.sv - shared constants for the radix-4 DIF butterfly pipeline
package butterfly_radix4_pipe_pkg;

    // Sample width (signed two's complement) for data inputs and outputs
    localparam int WIDTH    = 32;
    // Twiddle component width and its fractional bits (Q1.15)
    localparam int TW_WIDTH = WIDTH / 2;
    localparam int TW_FRAC  = 15;
    // Add/sub terms keep two guard bits so a+b+c+d never overflows
    localparam int TERM_W   = WIDTH + 2;
    // Edges from the start-sampling edge to the edge that raises done
    localparam int LATENCY  = 4;

endpackage

// File: rtl/butterfly_radix4_pipe_cmult.sv
// rtl/butterfly_radix4_pipe_cmult.sv - two-stage Q1.15 complex multiplier (products, then sum/shift/truncate)
module complex_mult_q15 #(
    parameter int XW   = 34,
    parameter int TWW  = 16,
    parameter int FRAC = 15,
    parameter int OW   = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic signed [XW-1:0]  xr_i,
    input  logic signed [XW-1:0]  xi_i,
    input  logic signed [TWW-1:0] wr_i,
    input  logic signed [TWW-1:0] wi_i,
    output logic signed [OW-1:0]  yr_o,
    output logic signed [OW-1:0]  yi_o
);

    // Full-precision product width, plus one bit for the sum of two products
    localparam int PW = XW + TWW;
    localparam int SW = PW + 1;

    logic signed [PW-1:0] rr_d, ii_d, ri_d, ir_d;
    logic signed [PW-1:0] rr_q, ii_q, ri_q, ir_q;
    logic signed [SW-1:0] sum_r, sum_i;
    logic signed [OW-1:0] yr_d, yi_d;
    logic signed [OW-1:0] yr_q, yi_q;

    // Four real partial products at full precision
    always_comb begin
        rr_d = PW'(xr_i) * PW'(wr_i);
        ii_d = PW'(xi_i) * PW'(wi_i);
        ri_d = PW'(xr_i) * PW'(wi_i);
        ir_d = PW'(xi_i) * PW'(wr_i);
    end

    // Product stage register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q <= '0;
            ii_q <= '0;
            ri_q <= '0;
            ir_q <= '0;
        end else begin
            rr_q <= rr_d;
            ii_q <= ii_d;
            ri_q <= ri_d;
            ir_q <= ir_d;
        end
    end

    // Combine products, floor-shift by the twiddle fraction, keep the low OW bits (wraps)
    always_comb begin
        sum_r = SW'(rr_q) - SW'(ii_q);
        sum_i = SW'(ri_q) + SW'(ir_q);
        yr_d  = OW'(sum_r >>> FRAC);
        yi_d  = OW'(sum_i >>> FRAC);
    end

    // Sum/shift/truncate stage register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            yr_q <= '0;
            yi_q <= '0;
        end else begin
            yr_q <= yr_d;
            yi_q <= yi_d;
        end
    end

    assign yr_o = yr_q;
    assign yi_o = yi_q;

endmodule

// File: rtl/butterfly_radix4_pipe.sv
// rtl/butterfly_radix4_pipe.sv - fully pipelined radix-4 DIF butterfly with twiddled outputs X1..X3
module butterfly_radix4_pipe
    import butterfly_radix4_pipe_pkg::*;
(
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic signed [WIDTH-1:0]    ar,
    input  logic signed [WIDTH-1:0]    ai,
    input  logic signed [WIDTH-1:0]    br,
    input  logic signed [WIDTH-1:0]    bi,
    input  logic signed [WIDTH-1:0]    cr,
    input  logic signed [WIDTH-1:0]    ci,
    input  logic signed [WIDTH-1:0]    dr,
    input  logic signed [WIDTH-1:0]    di,
    input  logic signed [TW_WIDTH-1:0] w0r,
    input  logic signed [TW_WIDTH-1:0] w0i,
    input  logic signed [TW_WIDTH-1:0] w1r,
    input  logic signed [TW_WIDTH-1:0] w1i,
    input  logic signed [TW_WIDTH-1:0] w2r,
    input  logic signed [TW_WIDTH-1:0] w2i,
    output logic                       done,
    output logic signed [WIDTH-1:0]    out1r,
    output logic signed [WIDTH-1:0]    out1i,
    output logic signed [WIDTH-1:0]    out2r,
    output logic signed [WIDTH-1:0]    out2i,
    output logic signed [WIDTH-1:0]    out3r,
    output logic signed [WIDTH-1:0]    out3i,
    output logic signed [WIDTH-1:0]    out4r,
    output logic signed [WIDTH-1:0]    out4i
);

    // Valid bits travelling alongside each stage
    logic v1_q, v2_q, v3_q, v4_q, done_q;

    // Stage 1: captured samples and twiddles
    logic signed [WIDTH-1:0]    ar_q, ai_q, br_q, bi_q, cr_q, ci_q, dr_q, di_q;
    logic signed [TW_WIDTH-1:0] w0r_q, w0i_q, w1r_q, w1i_q, w2r_q, w2i_q;

    // Stage 2: radix-2 intermediates and the four butterfly terms
    logic signed [TERM_W-1:0]   pr, pi, qr, qi, rr, ri, sr, si;
    logic signed [TERM_W-1:0]   t0r_d, t0i_d, t1r_d, t1i_d, t2r_d, t2i_d, t3r_d, t3i_d;
    logic signed [TERM_W-1:0]   t0r_q, t0i_q, t1r_q, t1i_q, t2r_q, t2i_q, t3r_q, t3i_q;
    logic signed [TW_WIDTH-1:0] w0r_q2, w0i_q2, w1r_q2, w1i_q2, w2r_q2, w2i_q2;

    // Stages 3-4: X0 delay line matching the multiplier depth
    logic signed [WIDTH-1:0]    x0r_q3, x0i_q3, x0r_q4, x0i_q4;

    // Multiplier results
    logic signed [WIDTH-1:0]    m1r, m1i, m2r, m2i, m3r, m3i;

    // Output registers
    logic signed [WIDTH-1:0]    o1r_q, o1i_q, o2r_q, o2i_q, o3r_q, o3i_q, o4r_q, o4i_q;

    // Valid shift register; reset flushes every in-flight vector and masks start
    always_ff @(posedge clock) begin
        if (reset) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            v4_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            v1_q   <= start;
            v2_q   <= v1_q;
            v3_q   <= v2_q;
            v4_q   <= v3_q;
            done_q <= v4_q;
        end
    end

    // Stage 1: capture a vector only when it is offered
    always_ff @(posedge clock) begin
        if (reset) begin
            ar_q  <= '0; ai_q  <= '0; br_q  <= '0; bi_q  <= '0;
            cr_q  <= '0; ci_q  <= '0; dr_q  <= '0; di_q  <= '0;
            w0r_q <= '0; w0i_q <= '0; w1r_q <= '0; w1i_q <= '0;
            w2r_q <= '0; w2i_q <= '0;
        end else if (start) begin
            ar_q  <= ar;  ai_q  <= ai;  br_q  <= br;  bi_q  <= bi;
            cr_q  <= cr;  ci_q  <= ci;  dr_q  <= dr;  di_q  <= di;
            w0r_q <= w0r; w0i_q <= w0i; w1r_q <= w1r; w1i_q <= w1i;
            w2r_q <= w2r; w2i_q <= w2i;
        end
    end

    // Radix-4 terms built from two radix-2 levels: (a+-c) and (b+-d), then +-j rotation of b-d
    always_comb begin
        pr = TERM_W'(ar_q) + TERM_W'(cr_q);
        pi = TERM_W'(ai_q) + TERM_W'(ci_q);
        qr = TERM_W'(ar_q) - TERM_W'(cr_q);
        qi = TERM_W'(ai_q) - TERM_W'(ci_q);
        rr = TERM_W'(br_q) + TERM_W'(dr_q);
        ri = TERM_W'(bi_q) + TERM_W'(di_q);
        sr = TERM_W'(br_q) - TERM_W'(dr_q);
        si = TERM_W'(bi_q) - TERM_W'(di_q);
        t0r_d = pr + rr;
        t0i_d = pi + ri;
        t2r_d = pr - rr;
        t2i_d = pi - ri;
        // q - j*s
        t1r_d = qr + si;
        t1i_d = qi - sr;
        // q + j*s
        t3r_d = qr - si;
        t3i_d = qi + sr;
    end

    // Stage 2: register the terms and carry the twiddles alongside
    always_ff @(posedge clock) begin
        if (reset) begin
            t0r_q  <= '0; t0i_q  <= '0; t1r_q  <= '0; t1i_q  <= '0;
            t2r_q  <= '0; t2i_q  <= '0; t3r_q  <= '0; t3i_q  <= '0;
            w0r_q2 <= '0; w0i_q2 <= '0; w1r_q2 <= '0; w1i_q2 <= '0;
            w2r_q2 <= '0; w2i_q2 <= '0;
        end else begin
            t0r_q  <= t0r_d; t0i_q  <= t0i_d; t1r_q  <= t1r_d; t1i_q  <= t1i_d;
            t2r_q  <= t2r_d; t2i_q  <= t2i_d; t3r_q  <= t3r_d; t3i_q  <= t3i_d;
            w0r_q2 <= w0r_q; w0i_q2 <= w0i_q; w1r_q2 <= w1r_q; w1i_q2 <= w1i_q;
            w2r_q2 <= w2r_q; w2i_q2 <= w2i_q;
        end
    end

    // Stages 3-4: X0 skips the multiplier, so delay it by the same two edges (low bits only)
    always_ff @(posedge clock) begin
        if (reset) begin
            x0r_q3 <= '0;
            x0i_q3 <= '0;
            x0r_q4 <= '0;
            x0i_q4 <= '0;
        end else begin
            x0r_q3 <= WIDTH'(t0r_q);
            x0i_q3 <= WIDTH'(t0i_q);
            x0r_q4 <= x0r_q3;
            x0i_q4 <= x0i_q3;
        end
    end

    complex_mult_q15 #(
        .XW   (TERM_W),
        .TWW  (TW_WIDTH),
        .FRAC (TW_FRAC),
        .OW   (WIDTH)
    ) u_mult1 (
        .clk_i (clock),
        .rst_i (reset),
        .xr_i  (t1r_q),
        .xi_i  (t1i_q),
        .wr_i  (w0r_q2),
        .wi_i  (w0i_q2),
        .yr_o  (m1r),
        .yi_o  (m1i)
    );

    complex_mult_q15 #(
        .XW   (TERM_W),
        .TWW  (TW_WIDTH),
        .FRAC (TW_FRAC),
        .OW   (WIDTH)
    ) u_mult2 (
        .clk_i (clock),
        .rst_i (reset),
        .xr_i  (t2r_q),
        .xi_i  (t2i_q),
        .wr_i  (w1r_q2),
        .wi_i  (w1i_q2),
        .yr_o  (m2r),
        .yi_o  (m2i)
    );

    complex_mult_q15 #(
        .XW   (TERM_W),
        .TWW  (TW_WIDTH),
        .FRAC (TW_FRAC),
        .OW   (WIDTH)
    ) u_mult3 (
        .clk_i (clock),
        .rst_i (reset),
        .xr_i  (t3r_q),
        .xi_i  (t3i_q),
        .wr_i  (w2r_q2),
        .wi_i  (w2i_q2),
        .yr_o  (m3r),
        .yi_o  (m3i)
    );

    // Output registers load only for valid results and otherwise hold their last value
    always_ff @(posedge clock) begin
        if (reset) begin
            o1r_q <= '0; o1i_q <= '0; o2r_q <= '0; o2i_q <= '0;
            o3r_q <= '0; o3i_q <= '0; o4r_q <= '0; o4i_q <= '0;
        end else if (v4_q) begin
            o1r_q <= x0r_q4; o1i_q <= x0i_q4;
            o2r_q <= m1r;    o2i_q <= m1i;
            o3r_q <= m2r;    o3i_q <= m2i;
            o4r_q <= m3r;    o4i_q <= m3i;
        end
    end

    assign done  = done_q;
    assign out1r = o1r_q;
    assign out1i = o1i_q;
    assign out2r = o2r_q;
    assign out2i = o2i_q;
    assign out3r = o3r_q;
    assign out3i = o3i_q;
    assign out4r = o4r_q;
    assign out4i = o4i_q;

endmodule

// File: tb/tb_butterfly_radix4_pipe.sv
// tb/tb_butterfly_radix4_pipe.sv - directed and seeded-random checks of the radix-4 butterfly pipeline
module tb_butterfly_radix4_pipe;

    typedef struct {
        int      ar, ai, br, bi, cr, ci, dr, di;
        shortint w0r, w0i, w1r, w1i, w2r, w2i;
    } vec_t;

    // Element 0..7 = X0r, X0i, X1r, X1i, X2r, X2i, X3r, X3i
    typedef logic [7:0][31:0] res_t;

    logic               clock;
    logic               reset;
    logic               start;
    logic signed [31:0] ar, ai, br, bi, cr, ci, dr, di;
    logic signed [15:0] w0r, w0i, w1r, w1i, w2r, w2i;
    logic               done;
    logic signed [31:0] out1r, out1i, out2r, out2i, out3r, out3i, out4r, out4i;

    int total = 0;
    int bad   = 0;
    string nm[8] = '{"x0r", "x0i", "x1r", "x1i", "x2r", "x2i", "x3r", "x3i"};
    res_t exp_q[$];

    butterfly_radix4_pipe dut (
        .clock (clock), .reset (reset), .start (start),
        .ar (ar), .ai (ai), .br (br), .bi (bi),
        .cr (cr), .ci (ci), .dr (dr), .di (di),
        .w0r (w0r), .w0i (w0i), .w1r (w1r), .w1i (w1i), .w2r (w2r), .w2i (w2i),
        .done (done),
        .out1r (out1r), .out1i (out1i), .out2r (out2r), .out2i (out2i),
        .out3r (out3r), .out3i (out3i), .out4r (out4r), .out4i (out4i)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input longint got, input longint want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, want);
        end
    endtask

    function automatic res_t mk_res(int x0r, int x0i, int x1r, int x1i,
                                    int x2r, int x2i, int x3r, int x3i);
        res_t r;
        r[0] = x0r; r[1] = x0i; r[2] = x1r; r[3] = x1i;
        r[4] = x2r; r[5] = x2i; r[6] = x3r; r[7] = x3i;
        return r;
    endfunction

    function automatic vec_t mk_vec(int a_r, int a_i, int b_r, int b_i, int c_r, int c_i,
                                    int d_r, int d_i, shortint wr, shortint wi);
        vec_t v;
        v.ar = a_r; v.ai = a_i; v.br = b_r; v.bi = b_i;
        v.cr = c_r; v.ci = c_i; v.dr = d_r; v.di = d_i;
        v.w0r = wr; v.w0i = wi; v.w1r = wr; v.w1i = wi; v.w2r = wr; v.w2i = wi;
        return v;
    endfunction

    // Complex multiply by a Q1.15 twiddle, floor-shifted, low 32 bits
    function automatic void cm(input longint xr, input longint xi, input shortint wr, input shortint wi,
                               output int yr, output int yi);
        longint pr, pq;
        pr = (xr * longint'(wr) - xi * longint'(wi)) >>> 15;
        pq = (xr * longint'(wi) + xi * longint'(wr)) >>> 15;
        yr = int'(pr);
        yi = int'(pq);
    endfunction

    // Direct expansion of the four butterfly equations
    function automatic res_t golden(vec_t v);
        longint a_r, a_i, b_r, b_i, c_r, c_i, d_r, d_i;
        int y[8];
        a_r = v.ar; a_i = v.ai; b_r = v.br; b_i = v.bi;
        c_r = v.cr; c_i = v.ci; d_r = v.dr; d_i = v.di;
        y[0] = int'(a_r + b_r + c_r + d_r);
        y[1] = int'(a_i + b_i + c_i + d_i);
        cm(a_r + b_i - c_r - d_i, a_i - b_r - c_i + d_r, v.w0r, v.w0i, y[2], y[3]);
        cm(a_r - b_r + c_r - d_r, a_i - b_i + c_i - d_i, v.w1r, v.w1i, y[4], y[5]);
        cm(a_r - b_i - c_r + d_i, a_i + b_r - c_i - d_r, v.w2r, v.w2i, y[6], y[7]);
        return mk_res(y[0], y[1], y[2], y[3], y[4], y[5], y[6], y[7]);
    endfunction

    task automatic apply(input vec_t v);
        ar = v.ar; ai = v.ai; br = v.br; bi = v.bi;
        cr = v.cr; ci = v.ci; dr = v.dr; di = v.di;
        w0r = v.w0r; w0i = v.w0i; w1r = v.w1r; w1i = v.w1i; w2r = v.w2r; w2i = v.w2i;
        start = 1'b1;
    endtask

    task automatic check_res(input string tag, input res_t e);
        res_t o;
        o = mk_res(out1r, out1i, out2r, out2i, out3r, out3i, out4r, out4i);
        for (int k = 0; k < 8; k++)
            check_val($sformatf("%s_%s", tag, nm[k]), longint'($signed(o[k])), longint'($signed(e[k])));
    endtask

    // One vector in, done exactly once four edges later, outputs held afterwards
    task automatic run_single(input string tag, input vec_t v, input res_t e);
        @(negedge clock);
        apply(v);
        for (int i = 0; i <= 5; i++) begin
            @(negedge clock);
            if (i == 0) start = 1'b0;
            check_val($sformatf("%s_done%0d", tag, i), longint'(done), longint'(i == 4));
            if (i == 4) check_res(tag, e);
            if (i == 5) check_res({tag, "_hold"}, e);
        end
    endtask

    vec_t v1, v2, v3, v4, vr;
    res_t e1, e2, e3, e4, er;
    int   ndone;

    initial begin
        v1 = mk_vec(100, 0, 0, 0, 0, 0, 0, 0, 16384, 0);
        e1 = mk_res(100, 0, 50, 0, 50, 0, 50, 0);
        v2 = mk_vec(0, 0, 0, 100, 0, 0, 0, 0, 0, 16384);
        e2 = mk_res(0, 100, 0, 50, 50, 0, 0, -50);
        v3 = mk_vec(-3, 0, 0, 0, 0, 0, 0, 0, 16384, 0);
        e3 = mk_res(-3, 0, -2, 0, -2, 0, -2, 0);
        v4 = mk_vec(2147483647, 0, 2147483647, 0, 2147483647, 0, 2147483647, 0, 16384, 0);
        e4 = mk_res(-4, 0, 0, 0, 0, 0, 0, 0);

        // Reset with start held high: nothing may emerge
        reset = 1'b1;
        apply(v1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check_val($sformatf("rst_done%0d", i), longint'(done), 0);
        end
        reset = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check_val($sformatf("idle_done%0d", i), longint'(done), 0);
        end
        check_res("idle", mk_res(0, 0, 0, 0, 0, 0, 0, 0));

        run_single("real", v1, e1);
        run_single("imag", v2, e2);
        run_single("floor", v3, e3);
        run_single("wrap", v4, e4);

        // Three back-to-back vectors, then idle
        @(negedge clock);
        apply(v1);
        for (int i = 0; i <= 8; i++) begin
            @(negedge clock);
            if (i == 0) apply(v2);
            else if (i == 1) apply(v3);
            else start = 1'b0;
            check_val($sformatf("strm_done%0d", i), longint'(done), longint'(i >= 4 && i <= 6));
            if (i == 4) check_res("strm0", e1);
            if (i == 5) check_res("strm1", e2);
            if (i == 6) check_res("strm2", e3);
            if (i == 8) check_res("strm_hold", e3);
        end

        // Reset while two vectors are in flight: both are discarded
        @(negedge clock);
        apply(v4);
        @(negedge clock);
        apply(v2);
        @(negedge clock);
        start = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_val("flush_done_rst", longint'(done), 0);
        check_res("flush_out", mk_res(0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            check_val($sformatf("flush_done%0d", i), longint'(done), 0);
        end

        // Seeded random stream with start held high
        void'($urandom(32'd20240611));
        ndone = 0;
        for (int n = 0; n < 512 + 8; n++) begin
            @(negedge clock);
            if (done) begin
                if (exp_q.size() == 0) begin
                    check_val("rnd_extra_done", 1, 0);
                end else begin
                    er = exp_q.pop_front();
                    check_res($sformatf("rnd%0d", ndone), er);
                    ndone++;
                end
            end
            if (n < 512) begin
                vr.ar = int'($urandom); vr.ai = int'($urandom);
                vr.br = int'($urandom); vr.bi = int'($urandom);
                vr.cr = int'($urandom); vr.ci = int'($urandom);
                vr.dr = int'($urandom); vr.di = int'($urandom);
                vr.w0r = shortint'($urandom); vr.w0i = shortint'($urandom);
                vr.w1r = shortint'($urandom); vr.w1i = shortint'($urandom);
                vr.w2r = shortint'($urandom); vr.w2i = shortint'($urandom);
                apply(vr);
                exp_q.push_back(golden(vr));
            end else begin
                start = 1'b0;
            end
        end
        check_val("rnd_count", longint'(ndone), 512);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
